// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler
//   Queues ASCII characters and launches them one at a time towards an
//   external Morse encoder / buzzer driver. It waits for the driver to
//   accept (drv_busy) and finish, then holds a silent inter-character gap
//   counted in Morse time units (rising edges of clk_5hz).
//
//   Build option: define MORSE_SCHED_WORDGAP_EN to queue spaces (0x20) and
//   play them as a WORD_GAP silent gap. Without it, space pushes are
//   discarded silently and WORD_GAP has no effect.
//
// Ports
//   clk, rst            1 MHz clock, synchronous active-high reset
//   clk_5hz             time-unit reference; each rising edge is one unit
//   en                  launch enable
//   char_in/char_valid  character push (one-clk strobe)
//   flush               empties the queue; the character in flight continues
//   tx_char             character being sent (held until the next pop)
//   drv_start           one-clk start pulse to the buzzer driver
//   drv_busy            buzzer driver busy
//   fifo_count          queued entries
//   fifo_full           queue full
//   overflow            sticky; set by a dropped push
//   sched_busy          scheduler not idle
module morse_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CHAR_GAP   = 3,
  parameter int unsigned WORD_GAP   = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_5hz,
  input  logic                          en,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  input  logic                          flush,
  output logic [7:0]                    tx_char,
  output logic                          drv_start,
  input  logic                          drv_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          sched_busy
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned GAP_MAX = (WORD_GAP > CHAR_GAP) ? WORD_GAP : CHAR_GAP;
  localparam int unsigned GW      = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [7:0]  SPACE   = 8'h20;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, PLAY, GAP} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [GW-1:0]   gap_cnt, gap_val;
  logic [1:0]      wait_cnt;
  logic            clk_5hz_q;
  logic            tick, fifo_empty, pop, push_ok, push_drop, load_gap;
  logic            launch_space, space_drop;

`ifdef MORSE_SCHED_WORDGAP_EN
  assign launch_space = (tx_char == SPACE);
  assign space_drop   = 1'b0;
`else
  assign launch_space = 1'b0;
  assign space_drop   = (char_in == SPACE);
`endif

  assign tick       = clk_5hz & ~clk_5hz_q;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign sched_busy = (state != IDLE);

  // A full queue still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok   = char_valid && !flush && !space_drop && (!fifo_full || pop);
  assign push_drop = char_valid && !flush && !space_drop && fifo_full && !pop;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_gap   = 1'b0;
    gap_val    = '0;
    drv_start  = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (launch_space) begin
          load_gap   = 1'b1;
          gap_val    = GW'(WORD_GAP);
          state_next = GAP;
        end else begin
          drv_start  = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (drv_busy)               state_next = PLAY;
        else if (wait_cnt == 2'd3)  state_next = IDLE;
      end
      PLAY: begin
        if (!drv_busy) begin
          load_gap   = 1'b1;
          gap_val    = GW'(CHAR_GAP);
          state_next = GAP;
        end
      end
      GAP: begin
        // Last unit of the gap: chain straight into the next launch if allowed.
        if (tick && gap_cnt <= GW'(1)) begin
          if (en && !fifo_empty) begin
            pop        = 1'b1;
            state_next = LAUNCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      tx_char    <= '0;
      gap_cnt    <= '0;
      wait_cnt   <= '0;
      clk_5hz_q  <= 1'b0;
    end else begin
      state     <= state_next;
      clk_5hz_q <= clk_5hz;

      if (push_drop) overflow <= 1'b1;
      if (pop)       tx_char  <= mem[rd_ptr];

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
        else if (pop && !push_ok) fifo_count <= fifo_count - 1'b1;
      end

      if (load_gap)                                   gap_cnt <= gap_val;
      else if (state == GAP && tick && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      wait_cnt <= (state == WAIT_ACK) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= char_in;
  end

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Testbench for morse_tx_scheduler: scoreboard of expected launch order,
// behavioural buzzer-driver model, and gap measurement in clk_5hz units.
module tb_morse_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int CG    = 3;
  localparam int WG    = 7;

  logic       clk = 1'b0, rst = 1'b1, clk_5hz = 1'b0, en = 1'b0;
  logic       char_valid = 1'b0, flush = 1'b0, drv_busy = 1'b0;
  logic [7:0] char_in = '0;
  logic [7:0] tx_char;
  logic       drv_start, fifo_full, overflow, sched_busy;
  logic [3:0] fifo_count;

  int  tests = 0, fails = 0, sent = 0;
  int  busy_units = 3;
  bit  refuse_next = 1'b0;
  bit  prev5 = 1'b0, prev_busy = 1'b0, gap_active = 1'b0;
  int  gap_ticks = 0, exp_gap = 0, div = 0;
  logic [7:0] model_q[$];

  morse_tx_scheduler #(.FIFO_DEPTH(DEPTH), .CHAR_GAP(CG), .WORD_GAP(WG)) dut (
    .clk(clk), .rst(rst), .clk_5hz(clk_5hz), .en(en), .char_in(char_in),
    .char_valid(char_valid), .flush(flush), .tx_char(tx_char), .drv_start(drv_start),
    .drv_busy(drv_busy), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .overflow(overflow), .sched_busy(sched_busy)
  );

  always #500 clk = ~clk;

  // Time-unit reference: period of 20 clk cycles.
  always @(posedge clk) begin
    #1;
    if (div == 9) begin div = 0; clk_5hz = ~clk_5hz; end
    else div++;
  end

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic void check_range(string name, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  // Buzzer driver model: busy one cycle after start, for busy_units units.
  initial begin
    forever begin
      @(negedge clk);
      if (drv_start && !rst) begin
        if (refuse_next) refuse_next = 1'b0;
        else begin
          @(posedge clk); #1 drv_busy = 1'b1;
          repeat (busy_units) @(posedge clk_5hz);
          repeat (3) @(posedge clk);
          #1 drv_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each launch against the scoreboard and measures gaps.
  always @(negedge clk) begin
    if (rst) begin
      gap_active = 1'b0;
      prev_busy  = 1'b0;
      prev5      = clk_5hz;
    end else begin
      if (drv_start) begin
        if (model_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_start: got tx_char 0x%0h, expected no launch", tx_char);
        end else begin
          check("tx_char", int'(tx_char), int'(model_q.pop_front()));
        end
        sent++;
        if (gap_active) begin
          check("gap_before_launch", gap_ticks, exp_gap);
          gap_active = 1'b0;
        end
      end
      if (gap_active && !sched_busy) begin
        check("gap_before_idle", gap_ticks, exp_gap);
        gap_active = 1'b0;
      end
      if (gap_active && clk_5hz && !prev5) gap_ticks++;
      if (prev_busy && !drv_busy) begin
        // Spaces queued right behind this character extend the silence.
        gap_active = 1'b1;
        gap_ticks  = 0;
        exp_gap    = CG;
        while (model_q.size() > 0 && model_q[0] == 8'h20) begin
          void'(model_q.pop_front());
          exp_gap += WG;
        end
      end
      prev_busy = drv_busy;
      prev5     = clk_5hz;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c);
    bit keep;
    keep = 1'b1;
`ifndef MORSE_SCHED_WORDGAP_EN
    keep = (c != 8'h20);
`endif
    char_in = c; char_valid = 1'b1;
    if (keep && model_q.size() < DEPTH) model_q.push_back(c);
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while ((sched_busy || fifo_count != 0 || drv_busy || gap_active) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (n >= limit) begin
      tests++; fails++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
    tick(2);
  endtask

  task automatic wait_start(input string name, input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!drv_start && n < limit);
    if (!drv_start) begin
      tests++; fails++;
      $display("FAIL %s: no drv_start within %0d cycles", name, limit);
    end
  endtask

  initial begin
    int n, s0, cnt;
    tick(3);
    check("rst_tx_char", int'(tx_char), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drv_start", int'(drv_start), 0);
    check("rst_sched_busy", int'(sched_busy), 0);
    rst = 1'b0;
    tick(2);

    // Single 'E'
    en = 1'b1; busy_units = 3;
    push(8'h45);
    wait_idle("E", 2000);
    check("tx_char_held", int'(tx_char), 8'h45);
    check("E_idle", int'(sched_busy), 0);

    // "SOS" back-to-back
    push(8'h53); push(8'h4F); push(8'h53);
    wait_idle("SOS", 4000);

    // 'A',' ','B'
    en = 1'b0;
    push(8'h41); push(8'h20); push(8'h42);
`ifdef MORSE_SCHED_WORDGAP_EN
    check("space_count", int'(fifo_count), 3);
`else
    check("space_count", int'(fifo_count), 2);
`endif
    check("space_no_ovf", int'(overflow), 0);
    en = 1'b1;
    wait_idle("space", 5000);

    // Flush during PLAY with a simultaneous push
    push(8'h4B);
    n = 0;
    while (!drv_busy && n < 50) begin tick(1); n++; end
    check("flush_busy_seen", int'(drv_busy), 1);
    push(8'h4C); push(8'h4D); push(8'h4E);
    check("flush_pre_count", int'(fifo_count), 3);
    flush = 1'b1; char_in = 8'h5A; char_valid = 1'b1;
    model_q.delete();
    tick(1);
    flush = 1'b0; char_valid = 1'b0;
    check("flush_count", int'(fifo_count), 0);
    check("flush_no_ovf", int'(overflow), 0);
    check("flush_char_continues", int'(sched_busy), 1);
    wait_idle("flush", 2000);

    // Driver refuses the first character
    en = 1'b0;
    push(8'h52); push(8'h55);
    refuse_next = 1'b1;
    en = 1'b1;
    wait_start("refuse_first", 20, n);
    wait_start("refuse_second", 50, n);
    check_range("refuse_relaunch_cycles", n, 4, 7);
    wait_idle("refuse", 2000);

    // Nine pushes with en low
    en = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h41 + 8'($urandom_range(0, 25)));
    check("ovf_count", int'(fifo_count), 8);
    check("ovf_full", int'(fifo_full), 1);
    check("ovf_flag", int'(overflow), 1);
    s0 = sent;
    en = 1'b1;
    wait_idle("ovf_drain", 8000);
    check("ovf_sent", sent - s0, 8);
    check("ovf_model_empty", model_q.size(), 0);

    // Reset during GAP
    push(8'h54); push(8'h4D);
    n = 0;
    while (!gap_active && n < 500) begin tick(1); n++; end
    check("gap_reached", int'(gap_active), 1);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("gaprst_tx_char", int'(tx_char), 0);
    check("gaprst_fifo_count", int'(fifo_count), 0);
    check("gaprst_fifo_full", int'(fifo_full), 0);
    check("gaprst_overflow", int'(overflow), 0);
    check("gaprst_drv_start", int'(drv_start), 0);
    check("gaprst_sched_busy", int'(sched_busy), 0);
    model_q.delete();
    rst = 1'b0;
    tick(2);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      busy_units = $urandom_range(1, 3);
      cnt = $urandom_range(1, 4);
      for (int k = 0; k < cnt; k++) begin
        push(8'h41 + 8'($urandom_range(0, 25)));
        tick($urandom_range(0, 15));
      end
      wait_idle("random", 4000);
    end
    check("model_drained", model_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
